// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame-state encoding and timing constants
package uart_pkg;
    localparam int UART_OVS   = 16;
    localparam int UART_DBITS = 8;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous idle-high line
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;
    // Resets to 1 so a held line never looks like a start edge out of reset
    always_ff @(posedge clk or negedge rst)
        if (!rst) {sync_q, meta_q} <= 2'b11;
        else      {sync_q, meta_q} <= {meta_q, d};
    assign q = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver with odd parity and one stop bit
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DBITS = UART_DBITS,
    parameter int OVS   = UART_OVS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             tick,
    output logic [DBITS-1:0] dout,
    output logic             rx_done,
    output logic             parity_err,
    output logic             frame_err
);
    logic rx_s;
    uart_state_e state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [DBITS-1:0] sh_q, sh_d, dout_q, dout_d;
    logic par_q, par_d, done_q, done_d, perr_q, perr_d, ferr_q, ferr_d;
    logic mid, last;

    sync_2ff u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

    assign mid  = tick && tick_q == 4'(OVS/2-1);
    assign last = tick && tick_q == 4'(OVS-1);

    // Next-state logic: counters advance on tick only; every transition clears them
    always_comb begin
        state_d = state_q;
        tick_d  = tick ? tick_q + 4'd1 : tick_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        dout_d  = dout_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: if (mid) begin
                state_d = rx_s ? ST_IDLE : ST_DATA;
                tick_d  = '0;
            end
            ST_DATA: if (last) begin
                sh_d   = DBITS'({rx_s, sh_q} >> 1);
                tick_d = '0;
                bit_d  = bit_q == 3'(DBITS-1) ? '0 : bit_q + 3'd1;
                if (bit_q == 3'(DBITS-1)) state_d = ST_PARITY;
            end
            ST_PARITY: if (last) begin
                par_d   = rx_s;
                tick_d  = '0;
                state_d = ST_STOP;
            end
            ST_STOP: if (last) begin
                dout_d  = sh_q;
                perr_d  = par_q != ~^sh_q;
                ferr_d  = !rx_s;
                done_d  = 1'b1;
                tick_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end

    assign dout       = dout_q;
    assign rx_done    = done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frame vectors plus glitch and mid-frame reset sequences
module tb_uart_receiver;
    logic clk = 1'b0, rst = 1'b0, rx = 1'b1, tick = 1'b0;
    logic [7:0] dout;
    logic rx_done, parity_err, frame_err;
    int npass = 0, ntot = 0;

    typedef struct { logic [7:0] d; logic p; logic f; } obs_t;
    obs_t q[$];

    typedef struct {
        logic [7:0] data;
        logic       pinv;
        logic       stop;
        logic [7:0] exp_d;
        logic       exp_p;
        logic       exp_f;
    } vec_t;
    vec_t vecs[6];

    uart_receiver #(.DBITS(8), .OVS(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tick(tick),
        .dout(dout), .rx_done(rx_done), .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // one-clk tick every 4 clks
    initial begin
        int tc = 0;
        forever begin
            @(negedge clk);
            tick = (tc == 3);
            tc = (tc + 1) % 4;
        end
    end

    // record each completed frame as seen on the outputs
    always @(negedge clk)
        if (rx_done) q.push_back('{dout, parity_err, frame_err});

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 2ms", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else npass++;
    endtask

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick) k++;
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        @(negedge clk);
        rx = b;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pinv, input logic stop);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        send_bit((~^d) ^ pinv, 16);
        send_bit(stop, stop ? 16 : 12);
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic check_frame(input string n, input logic [7:0] ed, input logic ep, input logic ef);
        obs_t o;
        chk({n, " done_count"}, q.size(), 1);
        if (q.size() > 0) begin
            o = q.pop_front();
            chk({n, " dout"}, o.d, ed);
            chk({n, " parity_err"}, o.p, ep);
            chk({n, " frame_err"}, o.f, ef);
        end
        q.delete();
    endtask

    initial begin
        logic [7:0] last_d;
        obs_t o;
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset dout", dout, 8'h00);
        chk("reset rx_done", rx_done, 1'b0);
        chk("reset parity_err", parity_err, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        rst = 1'b1;
        wait_ticks(20);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].pinv, vecs[i].stop);
            wait_ticks(32);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_p, vecs[i].exp_f);
        end

        // back-to-back: next start immediately follows the stop bit
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_ticks(32);
        chk("b2b done_count", q.size(), 2);
        if (q.size() == 2) begin
            o = q.pop_front();
            chk("b2b first dout", o.d, 8'h00);
            chk("b2b first errs", {o.p, o.f}, 2'b00);
            o = q.pop_front();
            chk("b2b second dout", o.d, 8'hFF);
            chk("b2b second errs", {o.p, o.f}, 2'b00);
        end
        q.delete();
        last_d = 8'hFF;

        // 4-tick glitch is rejected at mid-start
        send_bit(1'b0, 4);
        send_bit(1'b1, 40);
        chk("glitch done_count", q.size(), 0);
        chk("glitch dout held", dout, last_d);
        send_frame(8'h6E, 1'b0, 1'b1);
        wait_ticks(32);
        check_frame("post_glitch", 8'h6E, 1'b0, 1'b0);

        // reset in the middle of data bit 3
        send_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 16);
        send_bit(1'b0, 8);
        rst = 1'b0;
        #1;
        chk("async reset dout", dout, 8'h00);
        chk("async reset rx_done", rx_done, 1'b0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_ticks(200);
        chk("abort done_count", q.size(), 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_ticks(32);
        check_frame("after_reset", 8'h5A, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DBITS, default 8, number of data bits per frame (1..8).
REQ-002 Parameter OVS, default 16, ticks per bit period; fixed at 16 in this release.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 tick  input  1  one-clk-wide baud pulse at 16x bit rate, from the shared baud generator.
REQ-007 dout  output  DBITS  last received data word, LSB = first bit on line.
REQ-008 rx_done  output  1  one-clk pulse when a frame completes, good or bad.
REQ-009 parity_err  output  1  parity check result of the last frame, valid from rx_done.
REQ-010 frame_err  output  1  stop bit sampled low in the last frame, valid from rx_done.

Function
REQ-011 Frame format SHALL be: start (0), DBITS data bits LSB first, one odd-parity bit (the bit equals NOT XOR of the data), one stop bit (1).
REQ-012 rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s (2 clk latency).
REQ-013 FSM states SHALL be idle, start, data, parity, stop; a 4-bit tick counter and a 3-bit bit counter are cleared on every state entry.
REQ-014 idle: rx_s == 0 -> start; tick is ignored in idle.
REQ-015 start: on each tick increment the counter; on the tick where the count is 7 (mid-bit), rx_s == 0 -> data, and rx_s == 1 -> idle (glitch reject, no rx_done).
REQ-016 data: on the tick where the count is 15, shift rx_s into the MSB of the shift register; after DBITS bits -> parity, otherwise increment the bit counter.
REQ-017 parity: on the tick where the count is 15, capture rx_s as the received parity bit -> stop.
REQ-018 stop: on the tick where the count is 15, sample rx_s; register dout, parity_err and frame_err in the same clk; pulse rx_done for exactly one clk; -> idle.
REQ-019 parity_err SHALL be 1 iff the received parity bit != NOT XOR of the received data bits.
REQ-020 frame_err SHALL be 1 iff the stop sample is 0; the frame still completes and dout still updates.
REQ-021 dout, parity_err and frame_err SHALL hold their values until the next rx_done.
REQ-022 For DBITS < 8, the received word SHALL be right-aligned in dout.
REQ-023 rx_done to next start detection: the FSM re-arms in idle on the clk after rx_done, and a start edge arriving during the stop-bit tail SHALL be detected.
REQ-024 Counters SHALL advance only on tick; rx changes between ticks do not affect sampling except start detection in idle.

Reset
REQ-025 rst low SHALL immediately force: state idle, counters 0, shift register 0, dout 0, rx_done 0, parity_err 0, frame_err 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL abandon the frame with no rx_done; after rst rises the block waits for a fresh falling edge.

Structure
REQ-027 The state enum (idle, start, data, parity, stop), OVS and the default DBITS SHALL live in shared package uart_pkg, which the transmitter also uses.
REQ-028 The 2-flop synchronizer SHALL be a sub-module sync_2ff with reset value 1; there are no other sub-modules.

Verification
REQ-029 Connect to the transmitter, DBITS=8, send 0xA5 -> one rx_done, dout=0xA5, parity_err=0, frame_err=0.
REQ-030 Send 0x00 then 0xFF back-to-back, with start immediately after stop -> two rx_done pulses, dout 0x00 then 0xFF, no errors.
REQ-031 Drive a 0xA5 frame with the parity bit inverted -> rx_done, dout=0xA5, parity_err=1.
REQ-032 Drive a 0x3C frame with the stop bit held 0 -> rx_done, dout=0x3C, frame_err=1; the next valid frame 0x11 clears frame_err.
REQ-033 Pulse rx low for 4 ticks only -> FSM returns to idle with no rx_done and dout unchanged.
REQ-034 Assert rst during data bit 3 of a frame, release it, then send 0x5A -> no rx_done for the aborted frame; then rx_done with dout=0x5A.
